// File: rtl/loader_pkg.sv
// Shared definitions for the IMem UART boot loader.
//   loader_state_t      : loader FSM states
//   rx_state_t          : byte receiver states
//   SYNC_BYTE_DEFAULT   : frame start marker
//   CLKS_PER_BIT_115200 : bit period in CPU cycles for 115200 baud at the divided CPU clock
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT   = 8'hA5;
  localparam int unsigned CPU_CLK_HZ          = 50_000_000;
  localparam int unsigned UART_BAUD           = 115_200;
  localparam int unsigned CLKS_PER_BIT_115200 = CPU_CLK_HZ / UART_BAUD;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
//   CLK_CPU, RST_CPU : clock, asynchronous active-high reset
//   rx_i             : raw serial line, idle high, asynchronous
//   byte_o           : last received byte (valid with byte_valid_o)
//   byte_valid_o     : one-cycle pulse, stop bit was 1
//   frame_err_o      : one-cycle pulse, stop bit was 0 (no byte produced)
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic       CLK_CPU,
  input  logic       RST_CPU,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned     CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_d, ferr_d;

  always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
    if (RST_CPU) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_prev      <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_meta      <= rx_i;
      rx_sync      <= rx_meta;
      rx_prev      <= rx_sync;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      byte_valid_o <= valid_d;
      frame_err_o  <= ferr_d;
    end
  end

  // After the mid-point of the start bit the counter restarts, so every
  // following sample lands one full bit period later, i.e. at mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_sync) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rx_sync, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = rx_sync;
          ferr_d  = !rx_sync;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o = sh_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Serial boot loader: receives SYNC, LEN_HI, LEN_LO, LEN big-endian words
// and an 8-bit additive checksum, writes the words to IMem from address 0
// and releases the CPU once a complete, checksum-valid image has arrived.
//   CLK_CPU, RST_CPU : clock, asynchronous active-high reset
//   rx_i             : UART line (8N1, idle high)
//   imem_we_o        : one-cycle write strobe per word
//   imem_addr_o      : IMem word address
//   imem_wdata_o     : IMem write data
//   cpu_hold_o       : keep CPU in reset while high
//   load_done_o      : sticky image-loaded flag
//   load_err_o       : framing / overflow / checksum error in current frame
//   word_cnt_o       : words written in the current frame
module imem_uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int unsigned ADDR_W       = 10,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic              CLK_CPU,
  input  logic              RST_CPU,
  input  logic              rx_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_hold_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [15:0]       word_cnt_o
);

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  logic [7:0]    rx_byte;
  logic          byte_valid, frame_err;

  loader_state_t state_q, state_d;
  logic [7:0]    len_hi_q;
  logic [15:0]   len_q, len_nxt;
  logic [23:0]   asm_q;
  logic [1:0]    byte_idx_q;
  logic [7:0]    csum_q;
  logic          start_frame, data_byte;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK_CPU     (CLK_CPU),
    .RST_CPU     (RST_CPU),
    .rx_i        (rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(byte_valid),
    .frame_err_o (frame_err)
  );

  assign len_nxt = {len_hi_q, rx_byte};

  always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
    if (RST_CPU) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    data_byte   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (byte_valid && rx_byte == SYNC_BYTE) begin
          state_d     = ST_LEN_HI;
          start_frame = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (frame_err)       state_d = ST_ERR;
        else if (byte_valid) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (frame_err) state_d = ST_ERR;
        else if (byte_valid) begin
          if ({1'b0, len_nxt} > DEPTH) state_d = ST_ERR;
          else if (len_nxt == 16'd0)   state_d = ST_CSUM;
          else                         state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (frame_err) state_d = ST_ERR;
        else if (byte_valid) begin
          data_byte = 1'b1;
          // word_cnt has long since settled from the previous word here
          if (byte_idx_q == 2'd3 && word_cnt_o + 16'd1 == len_q) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (frame_err)       state_d = ST_ERR;
        else if (byte_valid) state_d = (rx_byte == csum_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
    if (RST_CPU) begin
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      load_done_o  <= 1'b0;
      load_err_o   <= 1'b0;
      word_cnt_o   <= '0;
      len_hi_q     <= '0;
      len_q        <= '0;
      asm_q        <= '0;
      byte_idx_q   <= '0;
      csum_q       <= '0;
    end else begin
      imem_we_o   <= 1'b0;
      load_done_o <= (state_q == ST_DONE);
      load_err_o  <= (state_d == ST_ERR);
      // address advances only after the strobe cycle
      if (imem_we_o) begin
        imem_addr_o <= imem_addr_o + ADDR_W'(1);
        word_cnt_o  <= word_cnt_o + 16'd1;
      end
      if (state_q == ST_LEN_HI && byte_valid) len_hi_q <= rx_byte;
      if (state_q == ST_LEN_LO && byte_valid) len_q    <= len_nxt;
      if (data_byte) begin
        asm_q      <= {asm_q[15:0], rx_byte};
        csum_q     <= csum_q + rx_byte;
        byte_idx_q <= byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          imem_we_o    <= 1'b1;
          imem_wdata_o <= {asm_q, rx_byte};
        end
      end
      if (start_frame) begin
        imem_addr_o <= '0;
        word_cnt_o  <= '0;
        csum_q      <= '0;
        byte_idx_q  <= '0;
      end
    end
  end

  assign cpu_hold_o = !load_done_o;

endmodule

// File: tb/tb_imem_uart_loader.sv
module tb_imem_uart_loader;
  localparam int unsigned CPB    = 4;
  localparam int unsigned AW     = 4;
  localparam int unsigned DEPTH  = 1 << AW;
  localparam int unsigned SETTLE = 8;
  typedef logic [7:0] bq_t[$];

  logic          CLK_CPU = 1'b0;
  logic          RST_CPU = 1'b1;
  logic          rx_i    = 1'b1;
  logic          imem_we_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;
  logic          cpu_hold_o, load_done_o, load_err_o;
  logic [15:0]   word_cnt_o;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .CLK_CPU     (CLK_CPU),
    .RST_CPU     (RST_CPU),
    .rx_i        (rx_i),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_wdata_o(imem_wdata_o),
    .cpu_hold_o  (cpu_hold_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o),
    .word_cnt_o  (word_cnt_o)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Reference model: frame-level parser over the received byte stream.
  bit          m_in, m_done, m_err;
  int          m_idx, m_n, m_wcnt;
  logic [7:0]  m_sum;
  logic [31:0] m_word;
  int unsigned exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] obs_data[$];
  bit          stat_valid = 0;

  task automatic model_reset();
    m_in = 0; m_done = 0; m_err = 0; m_idx = 0; m_n = 0; m_wcnt = 0;
    m_sum = '0; m_word = '0;
    exp_addr.delete(); exp_data.delete(); obs_data.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_done) return;
    if (!m_in) begin
      if (b == 8'hA5) begin
        m_in = 1; m_idx = 0; m_sum = '0; m_wcnt = 0; m_err = 0;
      end
      return;
    end
    m_idx++;
    if (m_idx == 1) m_n = int'(b) * 256;
    else if (m_idx == 2) begin
      m_n += int'(b);
      if (m_n > int'(DEPTH)) begin m_err = 1; m_in = 0; end
    end else if (m_idx <= 2 + 4 * m_n) begin
      m_word = {m_word[23:0], b};
      m_sum  = m_sum + b;
      if ((m_idx - 2) % 4 == 0) begin
        exp_addr.push_back(m_wcnt % DEPTH);
        exp_data.push_back(m_word);
        m_wcnt++;
      end
    end else begin
      if (b == m_sum) m_done = 1; else m_err = 1;
      m_in = 0;
    end
  endtask

  task automatic model_ferr();
    if (m_in && !m_done) begin m_err = 1; m_in = 0; end
  endtask

  // Single compare process.
  logic [AW-1:0] prev_addr = '0;
  bit            stat_prev = 0;
  always @(negedge CLK_CPU) begin
    if (RST_CPU) begin
      chk("rst_we",    32'(imem_we_o),    0);
      chk("rst_addr",  32'(imem_addr_o),  0);
      chk("rst_wdata", imem_wdata_o,      0);
      chk("rst_hold",  32'(cpu_hold_o),   1);
      chk("rst_done",  32'(load_done_o),  0);
      chk("rst_err",   32'(load_err_o),   0);
      chk("rst_wcnt",  32'(word_cnt_o),   0);
    end else begin
      if (imem_we_o) begin
        chk("write_expected", 32'(exp_addr.size() > 0), 1);
        chk("wr_addr_stable", 32'(imem_addr_o), 32'(prev_addr));
        if (exp_addr.size() > 0) begin
          chk("wr_addr", 32'(imem_addr_o), 32'(exp_addr[0]));
          chk("wr_data", imem_wdata_o, exp_data[0]);
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
        end
        obs_data.push_back(imem_wdata_o);
      end
      if (stat_valid) begin
        if (!stat_prev) chk("write_missing", 32'(exp_addr.size()), 0);
        chk("done", 32'(load_done_o), 32'(m_done));
        chk("err",  32'(load_err_o),  32'(m_err));
        chk("hold", 32'(cpu_hold_o),  32'(!m_done));
        chk("wcnt", 32'(word_cnt_o),  32'(m_wcnt));
      end
    end
    prev_addr <= imem_addr_o;
    stat_prev <= stat_valid;
  end

  task automatic line(input logic v, input int unsigned n);
    rx_i = v;
    if (n > 0) begin
      repeat (n) @(posedge CLK_CPU);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int unsigned gap);
    int unsigned g;
    stat_valid = 0;
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(b[i], CPB);
    line(stop_ok, CPB);
    if (stop_ok) model_byte(b); else model_ferr();
    g = (!stop_ok && gap < 4) ? 4 : gap;
    if (g >= SETTLE) begin
      line(1'b1, SETTLE);
      stat_valid = 1;
      line(1'b1, g - SETTLE);
    end else line(1'b1, g);
  endtask

  task automatic settle();
    line(1'b1, SETTLE);
    stat_valid = 1;
    line(1'b1, 4);
  endtask

  task automatic send_frame(input bq_t q, input int unsigned gap);
    foreach (q[i]) send_byte(q[i], 1'b1, gap);
    settle();
  endtask

  task automatic do_reset();
    stat_valid = 0;
    #2;
    RST_CPU = 1'b1;
    rx_i    = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK_CPU);
    #3 RST_CPU = 1'b0;
    @(posedge CLK_CPU); #1;
    line(1'b1, 4);
    stat_valid = 1;
    line(1'b1, 2);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, want finish before 1500000");
    $fatal(1);
  end

  initial begin
    bq_t f1, q;
    logic [7:0] b, s;
    int n, ferr_at;

    f1 = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
           8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h4C};
    model_reset();
    #23 RST_CPU = 1'b0;
    @(posedge CLK_CPU); #1;
    line(1'b1, 4);
    stat_valid = 1;
    line(1'b1, 4);

    // half-bit glitch in idle, then a back-to-back two-word frame
    line(1'b0, CPB / 2);
    line(1'b1, 3);
    send_frame(f1, 0);
    chk("t1_done", 32'(load_done_o), 1);
    chk("t1_hold", 32'(cpu_hold_o), 0);
    chk("t1_wcnt", 32'(word_cnt_o), 2);
    chk("t1_nwr",  32'(obs_data.size()), 2);
    chk("t1_w0",   obs_data[0], 32'h12345678);
    chk("t1_w1",   obs_data[1], 32'hDEADBEEF);
    chk("t1_csum", 32'(m_sum), 32'h4C);

    // leading noise, one word; later frame ignored once done
    do_reset();
    send_frame('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h07, 8'h07}, 10);
    chk("t2_done", 32'(load_done_o), 1);
    chk("t2_w0",   obs_data[0], 32'h00000007);
    send_frame(f1, 0);
    chk("t2_sticky_wcnt", 32'(word_cnt_o), 1);
    chk("t2_sticky_nwr",  32'(obs_data.size()), 1);

    // length overflow, then recovery with a good frame
    do_reset();
    send_frame('{8'hA5, 8'h00, 8'h11}, 10);
    chk("t3_err",  32'(load_err_o), 1);
    chk("t3_hold", 32'(cpu_hold_o), 1);
    chk("t3_nwr",  32'(obs_data.size()), 0);
    send_frame(f1, 0);
    chk("t3_err_clr", 32'(load_err_o), 0);
    chk("t3_done",    32'(load_done_o), 1);

    // checksum mismatch after one written word
    do_reset();
    send_frame('{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h05}, 10);
    chk("t4_err",  32'(load_err_o), 1);
    chk("t4_done", 32'(load_done_o), 0);
    chk("t4_w0",   obs_data[0], 32'h00000001);

    // first frame with checksum 4B is off by one
    do_reset();
    f1[11] = 8'h4B;
    send_frame(f1, 0);
    chk("t4b_err",  32'(load_err_o), 1);
    chk("t4b_wcnt", 32'(word_cnt_o), 2);
    f1[11] = 8'h4C;

    // framing error on the second data byte
    do_reset();
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b0, 0);
    settle();
    chk("t5_err", 32'(load_err_o), 1);
    chk("t5_nwr", 32'(obs_data.size()), 0);

    // reset mid-DATA, then a full frame from address 0
    do_reset();
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h12, 1'b1, 0);
    send_byte(8'h34, 1'b1, 0);
    do_reset();
    chk("t6_addr",  32'(imem_addr_o), 0);
    chk("t6_wdata", imem_wdata_o, 0);
    send_frame(f1, 0);
    chk("t6_done", 32'(load_done_o), 1);
    chk("t6_w0",   obs_data[0], 32'h12345678);

    // boundary: exactly 2**ADDR_W words
    do_reset();
    q = '{8'hA5, 8'h00, 8'h10};
    s = '0;
    repeat (4 * DEPTH) begin
      b = 8'($urandom);
      s = s + b;
      q.push_back(b);
    end
    q.push_back(s);
    send_frame(q, 0);
    chk("t7_done", 32'(load_done_o), 1);
    chk("t7_wcnt", 32'(word_cnt_o), 16);

    // randomized frames
    for (int it = 0; it < 8; it++) begin
      do_reset();
      q = {};
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        q.push_back(b);
      end
      n = int'($urandom_range(0, 5));
      q.push_back(8'hA5);
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      s = '0;
      repeat (4 * n) begin
        b = 8'($urandom);
        s = s + b;
        q.push_back(b);
      end
      q.push_back(($urandom_range(0, 2) == 0) ? s + 8'd1 : s);
      ferr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      foreach (q[i]) send_byte(q[i], i != ferr_at, ($urandom_range(0, 1) == 1) ? 0 : 10);
      settle();
    end

    stat_valid = 0;
    line(1'b1, 4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
